wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Writeback unit: the write-side initiator for the integer register file.
- Accepts results from the ALU and load/store unit (LSU) over valid/ready channels, sign/zero-extends load data, and buffers results in a small FIFO.
- Drains one write per granted cycle into the register file write port (write enable, destination address, write data).
- Publishes a pending-destination mask that the hazard logic uses to stall dependent reads.

Parameters:
- DEPTH, 2, number of FIFO entries; must be a power of two and at least 2.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted this cycle when high together with valid
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_ld_valid  in  1  load result valid
- o_ld_ready  out  1  load result accepted this cycle when high together with valid
- i_ld_rd  in  5  load destination register
- i_ld_word  in  32  raw aligned memory word
- i_ld_funct3  in  3  load type
- i_ld_offset  in  2  byte address bits [1:0]
- i_wr_gnt  in  1  register file write port granted this cycle
- o_wr  out  1  register file write enable
- o_rd  out  5  register file destination address
- o_write_data  out  32  register file write data
- o_pend_mask  out  32  bit r high while any FIFO entry targets register r; bit 0 always 0
- o_empty  out  1  FIFO empty

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO count, pointers and entry valids clear.
  - Next cycle: o_wr=0, o_rd=0, o_write_data=0, o_pend_mask=0, o_empty=1, both readies=1.
  - o_wr is also gated combinationally by rst_n, so no write occurs while reset is held.
- Readiness:
  - full = (count==DEPTH).
  - o_ld_ready = ~full.
  - o_alu_ready = ~full & ~i_ld_valid. Loads have fixed priority; at most one push per cycle.
  - Ready does not depend on a same-cycle pop (no pass-through).
- Push: a handshake enqueues {rd, data} at the clk edge. The entry is visible at the head the next cycle (minimum latency 1 cycle, accept to o_wr).
- rd==0: the handshake completes but nothing is enqueued. Count and o_pend_mask are unchanged.
- Load extraction (combinational, before enqueue):
  - 000 LB: byte at offset*8, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at offset[1]*16, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW, and all other codes: whole word.
  - Misaligned accesses are rejected upstream; offset[0] is ignored for halfwords.
- Drain:
  - o_rd and o_write_data always reflect the head entry (0 when empty).
  - o_wr = ~o_empty & i_wr_gnt & rst_n.
  - The head pops at the clk edge when o_wr=1.
- Simultaneous push and pop: count unchanged and pointers both advance. This is legal when the FIFO is full only as a pop; push is blocked while full.
- Ordering: strict FIFO. Two entries with the same rd are written in accept order.
- o_pend_mask: OR over valid entries of a one-hot decode of rd. It reflects registered state only, so it updates the cycle after push/pop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset mid-operation drops all buffered entries. The producer must re-issue.

Decomposition:
- Shared package: load funct3 localparams (LB, LH, LW, LBU, LHU) and the REG_ADDR_W=5 constant.
- One sub-module: wb_fifo, a parameterised DEPTH x 37-bit synchronous FIFO with push/pop, count, full/empty and entry-valid vector.
- Load extraction and the mask decode stay in wb_unit.

Test Plan:
- ALU push: rd=5, data=0xDEADBEEF, i_wr_gnt=1 -> next cycle o_wr=1, o_rd=5, o_write_data=0xDEADBEEF, o_pend_mask=0x20. Cycle after: o_empty=1, mask 0.
- Load extraction: word=0x8001F0AA.
  - LB offset 0 -> 0xFFFFFFAA.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF8001.
  - LHU offset 0 -> 0x0000F0AA.
- Backpressure: i_wr_gnt=0, push rd=1 then rd=2 (DEPTH=2) -> both readies=0, mask=0x6. Assert gnt -> writes rd=1 then rd=2 on consecutive cycles.
- Priority: ALU and load valid together -> o_alu_ready=0, load enqueued first, ALU accepted next cycle, writes in that order.
- rd=0 ALU push -> handshake completes, o_empty stays 1, no o_wr.
- Reset with 2 entries pending and gnt=1 -> no write during reset. After release: o_empty=1, mask=0, ready=1.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared constants for the writeback unit: register address width and load funct3 encodings.
package wb_unit_pkg;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding {tag, payload} entries; exposes per-entry valid and tag views.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    parameter int TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            entry_vld,
    output logic [DEPTH-1:0][TAG_W-1:0] entry_tag
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                        do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign entry_vld = vld_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_tag[i] = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        mem_d    = mem_q;
        if (do_push) begin
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            vld_d[wr_ptr_q]  = 1'b1;
            mem_d[wr_ptr_q]  = wdata;
        end
        if (do_pop) begin
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
            vld_d[rd_ptr_q]  = 1'b0;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU/load results into a FIFO and drains them into the register file.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_word,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_offset,
    input  logic                  i_wr_gnt,
    output logic                  o_wr,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [XLEN-1:0]       o_write_data,
    output logic [XLEN-1:0]       o_pend_mask,
    output logic                  o_empty
);
    localparam int ENTRY_W = REG_ADDR_W + XLEN;

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0]      funct3,
                                                     input logic [1:0]      offset);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        byte_s = 8'(word >> {offset, 3'b000});
        half_s = 16'(word >> {offset[1], 4'b0000});
        case (funct3)
            LB:      load_extract = XLEN'(byte_s);
            LBU:     load_extract = XLEN'($unsigned(byte_s));
            LH:      load_extract = XLEN'(half_s);
            LHU:     load_extract = XLEN'($unsigned(half_s));
            default: load_extract = word;
        endcase
    endfunction

    logic                         full, empty;
    logic                         ld_hs, alu_hs, push, pop;
    logic [REG_ADDR_W-1:0]        push_rd;
    logic [XLEN-1:0]              push_data;
    logic [ENTRY_W-1:0]           head;
    logic [DEPTH-1:0]             entry_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_tag;
    logic [XLEN-1:0]              pend_mask;

    // Loads win arbitration; readiness ignores any same-cycle pop.
    assign o_ld_ready  = ~full;
    assign o_alu_ready = ~full & ~i_ld_valid;
    assign ld_hs       = i_ld_valid & o_ld_ready;
    assign alu_hs      = i_alu_valid & o_alu_ready;
    assign push_rd     = ld_hs ? i_ld_rd : i_alu_rd;
    assign push_data   = ld_hs ? load_extract(i_ld_word, i_ld_funct3, i_ld_offset) : i_alu_data;
    assign push        = (ld_hs | alu_hs) & (push_rd != '0);

    assign o_wr         = ~empty & i_wr_gnt & rst_n;
    assign pop          = o_wr;
    assign o_empty      = empty;
    assign o_rd         = head[ENTRY_W-1 -: REG_ADDR_W];
    assign o_write_data = head[XLEN-1:0];

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (REG_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wdata     ({push_rd, push_data}),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .entry_vld (entry_vld),
        .entry_tag (entry_tag)
    );

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pend_mask[entry_tag[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign o_pend_mask = pend_mask;
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed vectors, corner sequences and a randomized queue model.
module tb_wb_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_alu_valid, o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_valid, o_ld_ready;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_word;
    logic [2:0]  i_ld_funct3;
    logic [1:0]  i_ld_offset;
    logic        i_wr_gnt, o_wr;
    logic [4:0]  o_rd;
    logic [31:0] o_write_data, o_pend_mask;
    logic        o_empty;

    int checks   = 0;
    int failures = 0;

    wb_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alu_valid  (i_alu_valid),
        .o_alu_ready  (o_alu_ready),
        .i_alu_rd     (i_alu_rd),
        .i_alu_data   (i_alu_data),
        .i_ld_valid   (i_ld_valid),
        .o_ld_ready   (o_ld_ready),
        .i_ld_rd      (i_ld_rd),
        .i_ld_word    (i_ld_word),
        .i_ld_funct3  (i_ld_funct3),
        .i_ld_offset  (i_ld_offset),
        .i_wr_gnt     (i_wr_gnt),
        .o_wr         (o_wr),
        .o_rd         (o_rd),
        .o_write_data (o_write_data),
        .o_pend_mask  (o_pend_mask),
        .o_empty      (o_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference load extraction from plain arithmetic on byte/halfword values.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f,
                                             input logic [1:0] off);
        longint unsigned b, h;
        b = (longint'(w) >> (8 * off)) % 256;
        h = (longint'(w) >> (16 * (off / 2))) % 65536;
        case (f)
            3'd0: return 32'((b >= 128) ? (b + 64'hFFFFFF00) : b);
            3'd4: return 32'(b);
            3'd1: return 32'((h >= 32768) ? (h + 64'hFFFF0000) : h);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[8];
    logic [36:0] q[$];

    task automatic clear_inputs();
        i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
        i_ld_valid = 0; i_ld_rd = 0; i_ld_word = 0; i_ld_funct3 = 0; i_ld_offset = 0;
        i_wr_gnt = 0;
    endtask

    task automatic alu_push(input logic [4:0] rd, input logic [31:0] d);
        i_alu_valid = 1; i_alu_rd = rd; i_alu_data = d;
        tick();
        i_alu_valid = 0;
    endtask

    initial begin
        ld_tab[0] = '{3'b000, 2'd0, 32'h8001F0AA, 32'hFFFFFFAA};
        ld_tab[1] = '{3'b100, 2'd3, 32'h8001F0AA, 32'h00000080};
        ld_tab[2] = '{3'b001, 2'd2, 32'h8001F0AA, 32'hFFFF8001};
        ld_tab[3] = '{3'b101, 2'd0, 32'h8001F0AA, 32'h0000F0AA};
        ld_tab[4] = '{3'b010, 2'd0, 32'h8001F0AA, 32'h8001F0AA};
        ld_tab[5] = '{3'b000, 2'd1, 32'h8001F0AA, 32'hFFFFFFF0};
        ld_tab[6] = '{3'b100, 2'd2, 32'h8001F0AA, 32'h00000001};
        ld_tab[7] = '{3'b001, 2'd1, 32'h8001F0AA, 32'hFFFFF0AA};

        rst_n = 0;
        clear_inputs();
        repeat (3) tick();
        rst_n = 1;
        settle();
        chk("rst_wr", 32'(o_wr), 0);
        chk("rst_rd", 32'(o_rd), 0);
        chk("rst_data", o_write_data, 0);
        chk("rst_mask", o_pend_mask, 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_alu_ready", 32'(o_alu_ready), 1);
        chk("rst_ld_ready", 32'(o_ld_ready), 1);

        // Single ALU result straight through
        i_wr_gnt = 1;
        alu_push(5'd5, 32'hDEADBEEF);
        settle();
        chk("alu_wr", 32'(o_wr), 1);
        chk("alu_rd", 32'(o_rd), 5);
        chk("alu_data", o_write_data, 32'hDEADBEEF);
        chk("alu_mask", o_pend_mask, 32'h20);
        tick();
        chk("alu_empty_after", 32'(o_empty), 1);
        chk("alu_mask_after", o_pend_mask, 0);

        // Load extraction vectors
        for (int i = 0; i < 8; i++) begin
            i_ld_valid = 1; i_ld_rd = 5'd3; i_ld_funct3 = ld_tab[i].f3;
            i_ld_offset = ld_tab[i].off; i_ld_word = ld_tab[i].word;
            tick();
            i_ld_valid = 0;
            settle();
            chk($sformatf("ld_vec%0d_data", i), o_write_data, ld_tab[i].exp);
            chk($sformatf("ld_vec%0d_rd", i), 32'(o_rd), 3);
            tick();
        end

        // Backpressure fills the FIFO, then drains in order
        i_wr_gnt = 0;
        alu_push(5'd1, 32'h11);
        alu_push(5'd2, 32'h22);
        settle();
        chk("bp_alu_ready", 32'(o_alu_ready), 0);
        chk("bp_ld_ready", 32'(o_ld_ready), 0);
        chk("bp_mask", o_pend_mask, 32'h6);
        chk("bp_no_wr", 32'(o_wr), 0);
        i_wr_gnt = 1;
        settle();
        chk("bp_wr1", 32'(o_wr), 1);
        chk("bp_rd1", 32'(o_rd), 1);
        chk("bp_data1", o_write_data, 32'h11);
        tick();
        chk("bp_wr2", 32'(o_wr), 1);
        chk("bp_rd2", 32'(o_rd), 2);
        chk("bp_data2", o_write_data, 32'h22);
        tick();
        chk("bp_empty", 32'(o_empty), 1);

        // Load has priority over a simultaneous ALU result
        i_wr_gnt = 0;
        i_alu_valid = 1; i_alu_rd = 5'd7; i_alu_data = 32'h77;
        i_ld_valid = 1; i_ld_rd = 5'd8; i_ld_funct3 = 3'b010; i_ld_offset = 0; i_ld_word = 32'h88;
        settle();
        chk("pri_alu_ready", 32'(o_alu_ready), 0);
        chk("pri_ld_ready", 32'(o_ld_ready), 1);
        tick();
        i_ld_valid = 0;
        settle();
        chk("pri_alu_ready2", 32'(o_alu_ready), 1);
        tick();
        i_alu_valid = 0;
        i_wr_gnt = 1;
        settle();
        chk("pri_rd1", 32'(o_rd), 8);
        chk("pri_data1", o_write_data, 32'h88);
        tick();
        chk("pri_rd2", 32'(o_rd), 7);
        chk("pri_data2", o_write_data, 32'h77);
        tick();
        chk("pri_empty", 32'(o_empty), 1);

        // rd==0 is accepted and dropped
        i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 32'h55;
        settle();
        chk("x0_ready", 32'(o_alu_ready), 1);
        tick();
        i_alu_valid = 0;
        settle();
        chk("x0_empty", 32'(o_empty), 1);
        chk("x0_no_wr", 32'(o_wr), 0);
        chk("x0_mask", o_pend_mask, 0);

        // Reset while entries are pending and the write port is granted
        i_wr_gnt = 0;
        alu_push(5'd9, 32'h99);
        alu_push(5'd10, 32'hAA);
        settle();
        chk("rstmid_mask", o_pend_mask, 32'h600);
        rst_n = 0;
        i_wr_gnt = 1;
        settle();
        chk("rstmid_no_wr_held", 32'(o_wr), 0);
        tick();
        chk("rstmid_no_wr", 32'(o_wr), 0);
        chk("rstmid_empty_in_rst", 32'(o_empty), 1);
        rst_n = 1;
        settle();
        chk("rstmid_empty", 32'(o_empty), 1);
        chk("rstmid_mask0", o_pend_mask, 0);
        chk("rstmid_alu_ready", 32'(o_alu_ready), 1);
        chk("rstmid_ld_ready", 32'(o_ld_ready), 1);
        chk("rstmid_wr0", 32'(o_wr), 0);
        tick();

        // Randomized traffic against a queue model
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        exp_full, exp_wr;
            logic [31:0] exp_mask;
            i_alu_valid = ($urandom_range(0, 9) < 6);
            i_alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i_alu_data  = $urandom;
            i_ld_valid  = ($urandom_range(0, 9) < 4);
            i_ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i_ld_word   = $urandom;
            i_ld_funct3 = 3'($urandom_range(0, 7));
            i_ld_offset = 2'($urandom_range(0, 3));
            i_wr_gnt    = ($urandom_range(0, 1) == 1);
            settle();
            exp_full = (q.size() == DEPTH);
            exp_wr   = (q.size() > 0) && i_wr_gnt;
            exp_mask = 0;
            foreach (q[k]) exp_mask = exp_mask | (32'h1 << q[k][36:32]);
            exp_mask[0] = 1'b0;
            chk("rnd_ld_ready", 32'(o_ld_ready), 32'(!exp_full));
            chk("rnd_alu_ready", 32'(o_alu_ready), 32'(!exp_full && !i_ld_valid));
            chk("rnd_wr", 32'(o_wr), 32'(exp_wr));
            chk("rnd_empty", 32'(o_empty), 32'(q.size() == 0));
            chk("rnd_rd", 32'(o_rd), (q.size() > 0) ? 32'(q[0][36:32]) : 0);
            chk("rnd_data", o_write_data, (q.size() > 0) ? q[0][31:0] : 0);
            chk("rnd_mask", o_pend_mask, exp_mask);
            if (exp_wr) void'(q.pop_front());
            if (!exp_full) begin
                if (i_ld_valid) begin
                    if (i_ld_rd != 0) q.push_back({i_ld_rd, ref_load(i_ld_word, i_ld_funct3, i_ld_offset)});
                end else if (i_alu_valid && i_alu_rd != 0) begin
                    q.push_back({i_alu_rd, i_alu_data});
                end
            end
            tick();
        end

        clear_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
